// File: rtl/bus_arbiter.sv
// Two-master round-robin bus arbiter with a hold timeout. Grant, mux select and
// abort pulse are registered so that no combinational path runs from requests to grant.
module bus_arbiter #(
  parameter int unsigned TIMEOUT = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] m_req,
  input  logic [1:0] m_done,
  output logic [1:0] grant,
  output logic       mux_sel,
  output logic       bus_busy,
  output logic       timeout_abort
);

  typedef enum logic [1:0] {IDLE, GRANT_M1, GRANT_M2, RELEASE} state_t;

  localparam logic [15:0] CNT_MAX = 16'(TIMEOUT - 1);

  state_t      state, state_nxt;
  logic [15:0] hold_cnt, hold_cnt_nxt;
  logic        last_owner, last_owner_nxt;  // 0 = master 1, 1 = master 2
  logic [1:0]  grant_nxt;
  logic        mux_sel_nxt;
  logic        abort_nxt;
  logic        owner;
  logic        pick_m2;

  assign owner   = (state == GRANT_M2);
  // On a tie the master that did not own the bus last goes first.
  assign pick_m2 = (m_req == 2'b10) || ((m_req == 2'b11) && !last_owner);

  // NOTE: every next-value gets a default before the case so no latch is inferred.
  always_comb begin
    state_nxt      = state;
    hold_cnt_nxt   = hold_cnt;
    last_owner_nxt = last_owner;
    mux_sel_nxt    = mux_sel;
    grant_nxt      = 2'b00;
    abort_nxt      = 1'b0;
    case (state)
      IDLE: begin
        if (m_req != 2'b00) begin
          state_nxt      = pick_m2 ? GRANT_M2 : GRANT_M1;
          grant_nxt      = pick_m2 ? 2'b10 : 2'b01;
          mux_sel_nxt    = pick_m2;
          last_owner_nxt = pick_m2;
          hold_cnt_nxt   = 16'd0;
        end
      end
      GRANT_M1, GRANT_M2: begin
        if (m_done[owner] || !m_req[owner]) begin
          state_nxt = RELEASE;
        end else if ((hold_cnt == CNT_MAX) && m_req[~owner]) begin
          state_nxt = RELEASE;
          abort_nxt = 1'b1;
        end else begin
          grant_nxt = grant;
          if (hold_cnt != CNT_MAX) hold_cnt_nxt = hold_cnt + 16'd1;
        end
      end
      RELEASE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      hold_cnt      <= 16'd0;
      last_owner    <= 1'b1;
      grant         <= 2'b00;
      mux_sel       <= 1'b0;
      timeout_abort <= 1'b0;
    end else begin
      state         <= state_nxt;
      hold_cnt      <= hold_cnt_nxt;
      last_owner    <= last_owner_nxt;
      grant         <= grant_nxt;
      mux_sel       <= mux_sel_nxt;
      timeout_abort <= abort_nxt;
    end
  end

  assign bus_busy = |grant;

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Two-master arbiter for the serial system bus. It decides which master drives the shared serial address/data lines and handshake signals toward the slave input ports. It issues a one-hot grant and a mux select, and holds the grant until the owning master signals completion or withdraws its request. It enforces fair round-robin between simultaneous requesters and a hold timeout that forces release when the other master is starved.

## Interface
- TIMEOUT, 1000: maximum grant hold in cycles while the other master is requesting; legal range 2..65535.
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- m_req  input  2  bus request, bit0 = master 1, bit1 = master 2; level, held for the whole transaction.
- m_done  input  2  end-of-transaction pulse from the owning master (bit per master); ignored for non-owners.
- grant  output  2  one-hot bus grant, registered; 2'b00 when bus free.
- mux_sel  output  1  bus mux select: 0 = master 1, 1 = master 2; holds last owner when idle.
- bus_busy  output  1  high whenever grant != 0.
- timeout_abort  output  1  one-cycle pulse when a grant is revoked by timeout.

## Operation
- Four states: IDLE, GRANT_M1, GRANT_M2, RELEASE. Reset enters IDLE.
- Reset values: grant=00, mux_sel=0, bus_busy=0, timeout_abort=0, hold counter=0, last_owner=master 2, so master 1 wins the first tie.
- IDLE, only m_req[0]: go to GRANT_M1.
- IDLE, only m_req[1]: go to GRANT_M2.
- IDLE, both requesting: grant the master that is not last_owner.
- IDLE, no request: stay in IDLE.
- On entering GRANT_Mx: grant=one-hot x, mux_sel=x, last_owner=x, hold counter cleared to 0.
- GRANT_Mx exit priority, evaluated each cycle in this order:
  - m_done[x]=1: go to RELEASE, no abort.
  - m_req[x]=0 (abandon): go to RELEASE, no abort.
  - counter==TIMEOUT-1 and other master requesting: go to RELEASE, pulse timeout_abort.
  - otherwise: stay, counter+1, saturating at TIMEOUT-1.
- A done pulse from the non-owning master is ignored.
- RELEASE: grant=00 for exactly one cycle (bus turnaround), then IDLE.
- Any m_done in IDLE or RELEASE is ignored.
- Counter is 16 bits, unsigned. It saturates at TIMEOUT-1 rather than wrapping.
- When the counter is saturated and the other master then requests, timeout fires on the next evaluation.

## Timing
- Request to grant: m_req sampled high in IDLE at edge N gives grant high after edge N+1 (1-cycle latency).
- Release to idle: m_done high at edge N gives grant=00 after N+1 (RELEASE) and state IDLE after N+2.
- Back-to-back ownership: a pending request gets its grant after N+3. The gap between grants is 2 cycles minimum.
- Timeout: with the other master requesting throughout, the owner holds grant for exactly TIMEOUT cycles.
- timeout_abort is high during the cycle grant first reads 00.
- m_done and a timeout in the same cycle: done wins, no timeout_abort.
- Reset asserted mid-grant: next edge gives grant=00, timeout_abort=0, state IDLE, last_owner=master 2. The in-flight transaction is dropped without an abort pulse.
- Outputs are registered. No combinational path exists from m_req or m_done to grant.

## Test plan
- Single request: reset, then m_req=01 → grant=01 one cycle later, mux_sel=0, bus_busy=1. Pulse m_done=01 → grant=00 next cycle, IDLE the cycle after.
- Tie and fairness: after reset, m_req=11 held, each owner pulses done 5 cycles after grant → grant sequence 01,00,10,00,01,00,10, with a 2-cycle gap each time.
- Timeout (TIMEOUT=8): master 1 granted, never sends done; m_req[1]=1 → grant=01 for exactly 8 cycles, then grant=00 with timeout_abort=1 for one cycle, then grant=10.
- No starvation, no timeout: master 1 holds 20 cycles with m_req[1]=0 (TIMEOUT=8) → no abort. Master 2 then requests → abort on the next cycle, then grant=10 two cycles after abort.
- Abandon and stray done: m_req[1] drops mid-grant → RELEASE without abort. m_done=01 while master 2 owns → no effect on grant.
- Reset mid-grant and simultaneous done/timeout: reset while grant=10 → grant=00 next edge. m_done[0] on the timeout cycle → timeout_abort stays 0.
